// File: rtl/fp16_multiplier_if.sv
// Operand/result bundle for the binary16 multiplier.
// master drives clk_en/dataa/datab and observes result, flags and busy/done.
// slave is the multiplier side: it samples the operands and drives the outputs.
interface fp16_multiplier_if;
  logic        clk_en;     // start request
  logic [15:0] dataa;      // left operand, binary16
  logic [15:0] datab;      // right operand, binary16
  logic [15:0] result;     // registered product
  logic        sign;       // always equals result[15]
  logic        overflow;   // product saturated to infinity
  logic        underflow;  // product flushed to zero (exponent too small)
  logic        busy;       // high whenever the multiplier is not idle
  logic        done;       // one-cycle pulse when result/flags are loaded

  modport master (
    output clk_en, dataa, datab,
    input  result, sign, overflow, underflow, busy, done
  );

  modport slave (
    input  clk_en, dataa, datab,
    output result, sign, overflow, underflow, busy, done
  );
endinterface

// File: rtl/fp16_multiplier.sv
// Sequential binary16 multiplier using an 11-step shift-add significand product.
// Latency: start accepted at end of cycle N -> done in cycle N+14; one result per 14 cycles.
// Backpressure: none; clk_en is only honoured in IDLE or DONE, otherwise ignored (no queuing).
// Ports: clock, resetn (sync, active-low) and bus (slave side of fp16_multiplier_if):
//   clk_en/dataa/datab in; result/sign/overflow/underflow/busy/done out.
module fp16_multiplier #(
  parameter int BIAS  = 15,
  parameter int SIG_W = 11
) (
  input logic              clock,
  input logic              resetn,
  fp16_multiplier_if.slave bus
);

  localparam int ACC_W = 2 * SIG_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_MULT,
    S_NORM,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [15:0]       a_q, b_q;
  logic [ACC_W-1:0]  mcand_q;
  logic [SIG_W-1:0]  mplier_q;
  logic [ACC_W-1:0]  acc_q;
  logic [3:0]        cnt_q;
  logic signed [6:0] exp_sum_q;
  logic              zero_q, inf_q;
  logic [15:0]       result_q, result_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic              accept;
  logic              hid_a, hid_b;
  logic              sgn;
  logic signed [7:0] exp_n;
  logic [SIG_W-2:0]  mant_n;

  // Truncation rounding discards the low product bits.
  logic unused_acc_lsbs;
  assign unused_acc_lsbs = ^acc_q[ACC_W-SIG_W-2:0];

  assign accept = bus.clk_en && (state_q == S_IDLE || state_q == S_DONE);
  assign hid_a  = |a_q[14:10];
  assign hid_b  = |b_q[14:10];
  assign sgn    = a_q[15] ^ b_q[15];

  // State register
  always_ff @(posedge clock) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.clk_en) state_d = S_UNPACK;
      S_UNPACK: state_d = S_MULT;
      S_MULT:   if (cnt_q == 4'(SIG_W - 1)) state_d = S_NORM;
      S_NORM:   state_d = S_DONE;
      S_DONE:   state_d = bus.clk_en ? S_UNPACK : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.busy = (state_q != S_IDLE);
    bus.done = (state_q == S_DONE);
  end

  // Normalisation: the product of two [1,2) significands lies in [1,4), so
  // the top accumulator bit decides whether the binary point moves by one.
  always_comb begin
    exp_n    = {exp_sum_q[6], exp_sum_q} + (acc_q[ACC_W-1] ? 8'sd1 : 8'sd0);
    mant_n   = acc_q[ACC_W-1] ? acc_q[ACC_W-2 -: SIG_W-1] : acc_q[ACC_W-3 -: SIG_W-1];
    result_d = {sgn, exp_n[4:0], mant_n};
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    if (inf_q) begin
      result_d = {sgn, 5'h1F, 10'h000};
      ovf_d    = 1'b1;
    end else if (zero_q) begin
      result_d = {sgn, 15'h0000};
    end else if (exp_n >= 8'sd31) begin
      result_d = {sgn, 5'h1F, 10'h000};
      ovf_d    = 1'b1;
    end else if (exp_n <= 8'sd0) begin
      result_d = {sgn, 15'h0000};
      unf_d    = 1'b1;
    end
  end

  // Datapath registers
  always_ff @(posedge clock) begin
    if (!resetn) begin
      a_q       <= '0;
      b_q       <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      exp_sum_q <= '0;
      zero_q    <= 1'b0;
      inf_q     <= 1'b0;
      result_q  <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      if (accept) begin
        a_q <= bus.dataa;
        b_q <= bus.datab;
      end
      case (state_q)
        S_UNPACK: begin
          mcand_q   <= {{SIG_W{1'b0}}, hid_a, a_q[9:0]};
          mplier_q  <= {hid_b, b_q[9:0]};
          acc_q     <= '0;
          cnt_q     <= '0;
          zero_q    <= !hid_a || !hid_b;
          inf_q     <= (&a_q[14:10]) || (&b_q[14:10]);
          exp_sum_q <= 7'(a_q[14:10]) + 7'(b_q[14:10]) - 7'(BIAS);
        end
        S_MULT: begin
          // Iterations always run to completion so latency never depends on data.
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 4'd1;
        end
        S_NORM: begin
          result_q <= result_d;
          ovf_q    <= ovf_d;
          unf_q    <= unf_d;
        end
        default: ;
      endcase
    end
  end

  assign bus.result    = result_q;
  assign bus.sign      = result_q[15];
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;

endmodule
